usb_tx: RTL and testbench

USB_TX -- requirements
Module: usb_tx

---
 rtl/usb_tx.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_usb_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx.sv
// usb_tx: USB full/low-speed style serial transmitter.
// The transmitter sends a SYNC byte, then a stream of payload bytes LSB first.
// It uses NRZI coding and inserts a stuffed bit after six consecutive ones.
// Each packet ends with an EOP (SE0 for two bit times, then J for one bit time).
// Payload arrives through a one-byte holding register using a valid/ready handshake.
// An empty holding register at a byte boundary, before the last byte has been
// handed over, aborts the packet with an EOP and a tx_error pulse.

module usb_tx #(
   parameter int CLKS_PER_BIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic       d_plus,
   output logic       d_minus,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // Line states as {d_plus, d_minus}
   localparam logic [1:0] LINE_J   = 2'b10;
   localparam logic [1:0] LINE_K   = 2'b01;
   localparam logic [1:0] LINE_SE0 = 2'b00;

   localparam logic [7:0] SYNC_BYTE = 8'h80;
   localparam logic [2:0] MAX_ONES  = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SYNC    = 3'd1,
      ST_DATA    = 3'd2,
      ST_EOP_SE0 = 3'd3,
      ST_EOP_J   = 3'd4
   } state_t;

   // NRZI: a zero toggles J<->K, a one keeps the current line state
   function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_v);
      logic [1:0] res;
      if (bit_v) begin
         res = line;
      end else begin
         res = (line == LINE_J) ? LINE_K : LINE_J;
      end
      return res;
   endfunction

   state_t           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [2:0]       bit_idx_q,   bit_idx_d;
   logic [2:0]       ones_q,      ones_d;
   logic [7:0]       shift_q,     shift_d;
   logic [7:0]       hold_q,      hold_d;
   logic             hold_full_q, hold_full_d;
   logic             last_xfer_q, last_xfer_d;
   logic             err_q,       err_d;
   logic             eop_cnt_q,   eop_cnt_d;
   logic [1:0]       line_q,      line_d;
   logic             ready_q,     ready_d;
   logic             busy_q,      busy_d;
   logic             done_q,      done_d;
   logic             error_q,     error_d;

   logic             wrap_s;
   logic             xfer_s;
   logic             send_s;
   logic             send_bit_s;

   assign wrap_s = (cnt_q == CNT_MAX);
   assign xfer_s = tx_valid & ready_q;

   // Next-state logic: bit timing, NRZI/stuffing, byte hand-off and EOP sequencing
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      ones_d      = ones_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      last_xfer_d = last_xfer_q;
      err_d       = err_q;
      eop_cnt_d   = eop_cnt_q;
      line_d      = line_q;
      done_d      = 1'b0;
      error_d     = 1'b0;
      send_s      = 1'b0;
      send_bit_s  = 1'b0;

      // Byte handshake into the holding register
      if (xfer_s) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
         last_xfer_d = last_xfer_q | tx_last;
      end else begin
         hold_d      = hold_q;
         hold_full_d = hold_full_q;
         last_xfer_d = last_xfer_q;
      end

      // Bit-period counter: parked at zero in IDLE, wraps every bit time
      if ((state_q == ST_IDLE) || wrap_s) begin
         cnt_d = CNT_ZERO;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            line_d = LINE_J;
            if (tx_start) begin
               state_d     = ST_SYNC;
               shift_d     = SYNC_BYTE;
               bit_idx_d   = 3'd0;
               ones_d      = 3'd0;
               hold_full_d = 1'b0;
               last_xfer_d = 1'b0;
               err_d       = 1'b0;
               eop_cnt_d   = 1'b0;
               send_s      = 1'b1;
               send_bit_s  = SYNC_BYTE[0];
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SYNC, ST_DATA: begin
            if (wrap_s) begin
               if (ones_q == MAX_ONES) begin
                  // Stuffed zero: toggle the line, keep the bit index
                  line_d = nrzi_next(line_q, 1'b0);
                  ones_d = 3'd0;
               end else if (bit_idx_q == 3'd7) begin
                  // Byte boundary
                  if (hold_full_q) begin
                     state_d     = ST_DATA;
                     shift_d     = hold_q;
                     hold_full_d = 1'b0;
                     bit_idx_d   = 3'd0;
                     send_s      = 1'b1;
                     send_bit_s  = hold_q[0];
                  end else if (xfer_s) begin
                     // Byte handed over exactly at the boundary: pass straight through
                     state_d     = ST_DATA;
                     shift_d     = tx_data;
                     hold_full_d = 1'b0;
                     bit_idx_d   = 3'd0;
                     send_s      = 1'b1;
                     send_bit_s  = tx_data[0];
                  end else if (last_xfer_q) begin
                     state_d   = ST_EOP_SE0;
                     line_d    = LINE_SE0;
                     eop_cnt_d = 1'b0;
                     ones_d    = 3'd0;
                  end else begin
                     // Underrun: abort with EOP, flag the error for the end
                     state_d   = ST_EOP_SE0;
                     line_d    = LINE_SE0;
                     eop_cnt_d = 1'b0;
                     ones_d    = 3'd0;
                     err_d     = 1'b1;
                  end
               end else begin
                  bit_idx_d  = bit_idx_q + 3'd1;
                  send_s     = 1'b1;
                  send_bit_s = shift_q[bit_idx_q + 3'd1];
               end
            end else begin
               state_d = state_q;
            end
         end

         ST_EOP_SE0: begin
            line_d = LINE_SE0;
            if (wrap_s) begin
               if (eop_cnt_q) begin
                  state_d   = ST_EOP_J;
                  line_d    = LINE_J;
                  eop_cnt_d = 1'b0;
               end else begin
                  eop_cnt_d = 1'b1;
               end
            end else begin
               eop_cnt_d = eop_cnt_q;
            end
         end

         ST_EOP_J: begin
            line_d = LINE_J;
            if (wrap_s) begin
               // tx_start is not looked at here; a new packet needs a start in IDLE
               state_d     = ST_IDLE;
               hold_full_d = 1'b0;
               last_xfer_d = 1'b0;
               bit_idx_d   = 3'd0;
               ones_d      = 3'd0;
               err_d       = 1'b0;
               if (err_q) begin
                  error_d = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end else begin
               state_d = ST_EOP_J;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            line_d      = LINE_J;
            hold_full_d = 1'b0;
            last_xfer_d = 1'b0;
            err_d       = 1'b0;
         end
      endcase

      // Apply one real data/sync bit and maintain the consecutive-ones count
      if (send_s) begin
         line_d = nrzi_next(line_q, send_bit_s);
         if (send_bit_s) begin
            ones_d = ones_q + 3'd1;
         end else begin
            ones_d = 3'd0;
         end
      end else begin
         send_bit_s = 1'b0;
      end

      ready_d = ~hold_full_d & ~last_xfer_d &
                ((state_d == ST_SYNC) | (state_d == ST_DATA));
      busy_d  = (state_d != ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= CNT_ZERO;
         bit_idx_q   <= 3'd0;
         ones_q      <= 3'd0;
         shift_q     <= 8'h00;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         last_xfer_q <= 1'b0;
         err_q       <= 1'b0;
         eop_cnt_q   <= 1'b0;
         line_q      <= LINE_J;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         ones_q      <= ones_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         last_xfer_q <= last_xfer_d;
         err_q       <= err_d;
         eop_cnt_q   <= eop_cnt_d;
         line_q      <= line_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign d_plus   = line_q[1];
   assign d_minus  = line_q[0];
   assign tx_ready = ready_q;
   assign tx_busy  = busy_q;
   assign tx_done  = done_q;
   assign tx_error = error_q;

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx: random and directed packets compared
// against a bit-stream reference model (sync + payload, NRZI, stuffing, EOP).

module tb_usb_tx;

   localparam int CPB = 8;
   localparam logic [1:0] SYM_J   = 2'b10;
   localparam logic [1:0] SYM_K   = 2'b01;
   localparam logic [1:0] SYM_SE0 = 2'b00;

   logic       clk = 1'b0;
   logic       rst;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       d_plus;
   logic       d_minus;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   usb_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .d_plus   (d_plus),
      .d_minus  (d_minus),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done),
      .tx_error (tx_error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] pkt_q[$];
   logic [1:0] exp_q[$];
   logic [1:0] cap_q[$];
   int  done_cnt, err_cnt, hs_cnt;
   bit  cap_en = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: line state every busy cycle, pulse counts, handshakes
   always @(negedge clk) begin
      if (cap_en) begin
         if (tx_busy) cap_q.push_back({d_plus, d_minus});
         if (tx_done) done_cnt++;
         if (tx_error) err_cnt++;
         if (tx_valid && tx_ready) hs_cnt++;
      end
   end

   // Reference: expected line symbol for every bit time of the packet
   task automatic build_expected();
      logic [1:0] line;
      int ones;
      logic [7:0] all_q[$];
      exp_q.delete();
      line = SYM_J;
      ones = 0;
      all_q.push_back(8'h80);
      foreach (pkt_q[k]) all_q.push_back(pkt_q[k]);
      foreach (all_q[k]) begin
         for (int i = 0; i < 8; i++) begin
            if (all_q[k][i]) begin
               ones++;
            end else begin
               line = (line == SYM_J) ? SYM_K : SYM_J;
               ones = 0;
            end
            exp_q.push_back(line);
            if (ones == 6) begin
               line = (line == SYM_J) ? SYM_K : SYM_J;
               exp_q.push_back(line);
               ones = 0;
            end
         end
      end
      exp_q.push_back(SYM_SE0);
      exp_q.push_back(SYM_SE0);
      exp_q.push_back(SYM_J);
   endtask

   task automatic pulse_start();
      tx_start = 1'b1;
      @(posedge clk); #1;
      tx_start = 1'b0;
   endtask

   task automatic drive_byte(input logic [7:0] d, input bit last, input int max_gap);
      int gap;
      int t;
      bit ok;
      gap = $urandom_range(max_gap, 0);
      t = 0;
      ok = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      tx_data  = d;
      tx_last  = last;
      tx_valid = 1'b1;
      while (!ok && t < 500) begin
         @(negedge clk);
         ok = tx_ready;
         @(posedge clk); #1;
         t++;
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      if (!ok) check_eq("hs_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (tx_busy && t < 3000);
      if (t >= 3000) check_eq("idle_timeout", 32'd0, 32'd1);
   endtask

   // Send pkt_q as one packet and compare against the model
   task automatic run_packet(input string name, input bit underrun, input int max_gap, input bit busy_start);
      logic [1:0] val;
      cap_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      hs_cnt   = 0;
      cap_en   = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      for (int i = 0; i < pkt_q.size(); i++) begin
         drive_byte(pkt_q[i], (i == pkt_q.size() - 1) && !underrun, max_gap);
         if (busy_start && i == 1) begin
            repeat (10) begin @(posedge clk); #1; end
            pulse_start();
         end
      end
      wait_idle();
      repeat (3) @(negedge clk);
      cap_en = 1'b0;
      build_expected();
      check_eq({name, "_len"}, cap_q.size(), exp_q.size() * CPB);
      for (int k = 0; k < exp_q.size() && (k + 1) * CPB <= cap_q.size(); k++) begin
         val = cap_q[k * CPB];
         for (int j = 0; j < CPB; j++) begin
            if (cap_q[k * CPB + j] !== exp_q[k]) val = cap_q[k * CPB + j];
         end
         check_eq({name, "_line"}, val, exp_q[k]);
      end
      check_eq({name, "_done"}, done_cnt, underrun ? 0 : 1);
      check_eq({name, "_error"}, err_cnt, underrun ? 1 : 0);
      check_eq({name, "_hs"}, hs_cnt, pkt_q.size());
      check_eq({name, "_idle_ready"}, tx_ready, 1'b0);
      check_eq({name, "_idle_line"}, {d_plus, d_minus}, SYM_J);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst      = 1'b1;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_line", {d_plus, d_minus}, SYM_J);
      check_eq("rst_busy", tx_busy, 1'b0);
      check_eq("rst_ready", tx_ready, 1'b0);
      check_eq("rst_done", tx_done, 1'b0);
      check_eq("rst_error", tx_error, 1'b0);

      // tx_valid in IDLE is not accepted
      hs_cnt = 0;
      cap_en = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      repeat (5) begin @(posedge clk); #1; end
      tx_valid = 1'b0;
      cap_en = 1'b0;
      check_eq("idle_valid_hs", hs_cnt, 0);
      check_eq("idle_valid_busy", tx_busy, 1'b0);

      // Single byte 0xA5
      pkt_q = {8'hA5};
      run_packet("a5", 1'b0, 0, 1'b0);
      check_eq("a5_cycles", cap_q.size(), 152);

      // Stuffing with 0xFF
      pkt_q = {8'hFF};
      run_packet("ff", 1'b0, 5, 1'b0);
      check_eq("ff_bits", exp_q.size(), 8 + 9 + 3);

      // Underrun after first byte
      pkt_q = {8'h5A};
      run_packet("underrun", 1'b1, 3, 1'b0);

      // tx_start while busy
      pkt_q = {8'h12, 8'h34, 8'h56};
      run_packet("busy_start", 1'b0, 0, 1'b1);

      // Back-to-back stream
      pkt_q = {8'h00, 8'h01, 8'h02};
      run_packet("b2b", 1'b0, 0, 1'b0);

      // Randomized packets
      for (int p = 0; p < 10; p++) begin
         int n;
         bit ur;
         n  = $urandom_range(4, 1);
         ur = ($urandom_range(3, 0) == 0);
         pkt_q.delete();
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(2, 0) == 0) pkt_q.push_back(8'hFF);
            else pkt_q.push_back(8'($urandom));
         end
         run_packet("rand", ur, 20, 1'b0);
      end

      // Reset in the middle of a packet
      done_cnt = 0;
      err_cnt  = 0;
      hs_cnt   = 0;
      cap_en   = 1'b1;
      @(posedge clk); #1;
      pulse_start();
      drive_byte(8'hFF, 1'b0, 0);
      repeat (60) begin @(posedge clk); #1; end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("midrst_line", {d_plus, d_minus}, SYM_J);
      check_eq("midrst_busy", tx_busy, 1'b0);
      check_eq("midrst_ready", tx_ready, 1'b0);
      repeat (40) @(negedge clk);
      cap_en = 1'b0;
      check_eq("midrst_done", done_cnt, 0);
      check_eq("midrst_error", err_cnt, 0);
      check_eq("midrst_idle_busy", tx_busy, 1'b0);

      // Recovery after reset
      pkt_q = {8'hC3, 8'h7E};
      run_packet("after_rst", 1'b0, 10, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
